cpu_mem_arbiter: RTL
====================

// Module: cpu_mem_arbiter
// PURPOSE
//  Shares one external memory port between the CPU instruction-fetch (imem) and data (dmem) requesters.
//  Sits between cpu_top and the memory controller; the CPU-side ports carry the same held-request / ready-pulse semantics as cpu_top's imem/dmem ports.
//  Dmem has priority; a streak limiter prevents fetch starvation. One transaction is in flight at a time.
// PARAMETERS
//  ADDR_WIDTH      32   address width, all ports
//  DATA_WIDTH      32   data width, all ports
//  DMEM_STREAK_MAX 4    consecutive dmem grants allowed while imem waits (legal range >=1)
//  TIMEOUT_CYCLES  256  mem_ack wait limit in cycles; used only with CPU_MEM_ARB_TIMEOUT_EN
// PORTS
//  clk              in   1    clock; single clock domain
//  rst_n            in   1    asynchronous active-low reset
//  imem_addr        in   AW   fetch address
//  imem_read        in   1    fetch request; held until imem_ready
//  imem_read_data   out  DW   fetch data; valid while imem_ready=1
//  imem_ready       out  1    one-cycle completion pulse
//  dmem_addr        in   AW   data address
//  dmem_write_data  in   DW   store data
//  dmem_read        in   1    load request; held until dmem_ready
//  dmem_write       in   1    store request; held until dmem_ready
//  dmem_byte_enable in   4    store byte lanes
//  dmem_read_data   out  DW   load data; valid while dmem_ready=1
//  dmem_ready       out  1    one-cycle completion pulse
//  mem_req          out  1    shared-port request; held until mem_ack
//  mem_we           out  1    1 = write
//  mem_addr         out  AW   shared-port address
//  mem_wdata        out  DW   shared-port write data
//  mem_be           out  4    byte enables; 4'hF on reads
//  mem_rdata        in   DW   read data; sampled when mem_ack=1
//  mem_ack          in   1    transaction complete
//  bus_error        out  1    one-cycle timeout pulse, coincident with ready
// BEHAVIOUR
//  - Reset: every output is 0 and state is IDLE. The streak counter and the read-data registers clear.
//  - All outputs are registered. States: IDLE, GNT_I, GNT_D, RESP.
//  - IDLE arbitration happens at the clock edge:
//    * dmem pending and (imem idle or streak < DMEM_STREAK_MAX) -> GNT_D.
//    * otherwise, if imem is pending -> GNT_I.
//  - Streak counter:
//    * increments on each GNT_D entry while imem_read=1, saturating at DMEM_STREAK_MAX.
//    * clears on GNT_I entry, and when imem_read=0 at a dmem grant.
//  - Grant entry latches the request's addr, data, byte enables and we into the mem_* registers and sets mem_req=1.
//  - GNT_x: mem_req and all mem_* fields are held stable until mem_ack.
//  - On mem_ack: capture mem_rdata, drop mem_req, go to RESP.
//  - RESP (exactly 1 cycle): pulse the granted requester's ready with its read_data valid, then return to IDLE.
//    * No arbitration happens in RESP, so a still-held request is not reissued.
//  - Latency: request sampled at edge N -> mem_req=1 from N+1. mem_ack in cycle K -> ready in cycle K+1. Earliest next grant is K+2.
//  - dmem_read and dmem_write both high: treated as a write; read is ignored.
//  - Stores: dmem_ready pulses with dmem_read_data=0.
//  - mem_ack outside GNT_x is ignored.
//  - Requests dropped before ready: a transaction already in progress completes; its ready pulse is issued regardless.
//  - rst_n low mid-transaction: mem_req drops immediately (asynchronous) and no ready is issued.
// CONFIGURATION
//  Macro CPU_MEM_ARB_TIMEOUT_EN.
//  - Defined: a cycle counter runs in GNT_x. When it reaches TIMEOUT_CYCLES without mem_ack:
//    * drop mem_req and go to RESP;
//    * return read data 32'hDEADBEEF;
//    * pulse bus_error=1 with the ready.
//  - Undefined: GNT_x waits indefinitely and bus_error is tied to 0. The port exists in both builds.
// STRUCTURE
//  - Package cpu_mem_pkg holds:
//    * arb_state_t enum {IDLE, GNT_I, GNT_D, RESP};
//    * grant_t enum {GRANT_I, GRANT_D};
//    * localparam BUS_ERR_DATA = 32'hDEADBEEF.
//  - Sub-module cpu_mem_watchdog (timeout counter with start/clear/expired) is instantiated only under CPU_MEM_ARB_TIMEOUT_EN.
// TESTING
//  1. imem_read=1 at 0x100, mem_ack two cycles after mem_req, mem_rdata=0x00000013:
//     mem_req 1 cycle after the request, imem_ready 1 cycle after ack, imem_read_data=0x13.
//  2. imem and dmem_read (0x2000) requested together: dmem granted first (mem_addr=0x2000, mem_we=0), imem granted after dmem_ready.
//  3. dmem requests back-to-back with imem held, DMEM_STREAK_MAX=4:
//     exactly 4 dmem grants, then an imem grant, then dmem resumes.
//  4. dmem_write=1, dmem_read=1, be=4'b0011, data=0xA5A5A5A5:
//     mem_we=1, mem_be=0011, mem_wdata=0xA5A5A5A5, dmem_ready with dmem_read_data=0.
//  5. rst_n low in GNT_D: mem_req=0 immediately, no dmem_ready, state IDLE after release.
//  6. With CPU_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and mem_ack never asserted:
//     ready and bus_error pulse together, read data 0xDEADBEEF, mem_req=0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/cpu_mem_watchdog.sv
// Cycle counter for an outstanding memory transaction; expired asserts once
// the transaction has been waiting TIMEOUT_CYCLES cycles.
module cpu_mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic          running_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (clear) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            count_reg   <= '0;
            running_reg <= 1'b1;
        end else if (running_reg && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = running_reg && (count_reg == LAST);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between CPU fetch and data requesters; dmem has
// priority subject to a streak limit. Optional timeout: CPU_MEM_ARB_TIMEOUT_EN.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DMEM_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_read,
    output logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  imem_ready,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [3:0]            dmem_byte_enable,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_error
);

    localparam int SW = $clog2(DMEM_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DMEM_STREAK_MAX);

    if (DMEM_STREAK_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cpu_mem_arbiter: DMEM_STREAK_MAX and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t            state_reg;
    logic                  mem_req_reg, mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [3:0]            mem_be_reg;
    logic                  imem_ready_reg, dmem_ready_reg;
    logic [DATA_WIDTH-1:0] imem_rdata_reg, dmem_rdata_reg;
    logic [SW-1:0]         streak_reg, streak_next;

    logic                  grant_d, grant_i, resp_fire;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [3:0]            dmem_be_sel;

    // Reads always use all four lanes; only stores carry the CPU's enables.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_be_lane
        assign dmem_be_sel[gi] = dmem_write ? dmem_byte_enable[gi] : 1'b1;
    end

`ifdef CPU_MEM_ARB_TIMEOUT_EN
    logic wd_expired, resp_err, bus_error_reg;

    cpu_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (grant_d | grant_i),
        .clear  (resp_fire),
        .expired(wd_expired)
    );
`endif

    always_comb begin
        grant_d = (state_reg == IDLE) && (dmem_read || dmem_write) &&
                  (!imem_read || (streak_reg < STREAK_MAX));
        grant_i = (state_reg == IDLE) && !grant_d && imem_read;

        streak_next = '0;
        if (imem_read) begin
            streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 1'b1;
        end

        resp_fire = 1'b0;
        resp_data = mem_rdata;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
        resp_err  = 1'b0;
`endif
        if (state_reg == GNT_I || state_reg == GNT_D) begin
            if (mem_ack) begin
                resp_fire = 1'b1;
                resp_data = mem_we_reg ? '0 : mem_rdata;
            end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
            else if (wd_expired) begin
                resp_fire = 1'b1;
                resp_data = DATA_WIDTH'(BUS_ERR_DATA);
                resp_err  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= '0;
            imem_ready_reg <= 1'b0;
            dmem_ready_reg <= 1'b0;
            imem_rdata_reg <= '0;
            dmem_rdata_reg <= '0;
            streak_reg     <= '0;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
            bus_error_reg  <= 1'b0;
`endif
        end else begin
            imem_ready_reg <= 1'b0;
            dmem_ready_reg <= 1'b0;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
            bus_error_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg     <= GNT_D;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dmem_write;
                        mem_addr_reg  <= dmem_addr;
                        mem_wdata_reg <= dmem_write_data;
                        mem_be_reg    <= dmem_be_sel;
                        streak_reg    <= streak_next;
                    end else if (grant_i) begin
                        state_reg     <= GNT_I;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= imem_addr;
                        mem_wdata_reg <= '0;
                        mem_be_reg    <= 4'hF;
                        streak_reg    <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (resp_fire) begin
                        state_reg   <= RESP;
                        mem_req_reg <= 1'b0;
                        if (state_reg == GNT_D) begin
                            dmem_ready_reg <= 1'b1;
                            dmem_rdata_reg <= resp_data;
                        end else begin
                            imem_ready_reg <= 1'b1;
                            imem_rdata_reg <= resp_data;
                        end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
                        bus_error_reg <= resp_err;
`endif
                    end
                end
                // The held request is ignored here so it is not reissued.
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign mem_be         = mem_be_reg;
    assign imem_ready     = imem_ready_reg;
    assign dmem_ready     = dmem_ready_reg;
    assign imem_read_data = imem_rdata_reg;
    assign dmem_read_data = dmem_rdata_reg;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
    assign bus_error      = bus_error_reg;
`else
    assign bus_error      = 1'b0;
`endif

endmodule
